// File: rtl/adc128s_fc_model.sv
// adc128s_fc_model: clocked behavioural model of an 8-channel, 12-bit SPI A2D.
// Each 16-bit frame carries a channel command on MOSI. MISO returns the
// conversion of the channel that was commanded in the previous frame.
// All SPI pins are oversampled on clk through SYNC_STAGES-deep synchronizers.
// Optional feature macro: ADC_FRAME_CNT_EN adds frame_cnt[7:0], a wrapping
// count of valid (16-bit) frames.
module adc128s_fc_model #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
`ifdef ADC_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t state;
    state_t next_state;

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   ss_prev;
    logic                   sclk_prev;

    logic ss_cur;
    logic sclk_cur;
    logic mosi_cur;
    logic ss_fall;
    logic ss_rise;
    logic sclk_rise;
    logic sclk_fall;

    logic [15:0] rx_shft;
    logic [15:0] tx_shft;
    logic [4:0]  bit_cnt;
    logic [2:0]  chnl_ptr;
    logic [11:0] chnl_val;
    logic        frame_ok;

    // Only the low 15 bits of rx_shft feed back into the shifter; bit 15 is
    // shifted out and never needed.
    logic unused_rx_msb;
    assign unused_rx_msb = rx_shft[15];

    // Synchronize the SPI pins and keep one extra delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '1;
            mosi_sync <= '1;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            ss_prev   <= ss_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign ss_cur    = ss_sync[SYNC_STAGES-1];
    assign sclk_cur  = sclk_sync[SYNC_STAGES-1];
    assign mosi_cur  = mosi_sync[SYNC_STAGES-1];
    assign ss_fall   = ss_prev & ~ss_cur;
    assign ss_rise   = ~ss_prev & ss_cur;
    // An SCLK edge coinciding with an SS_n edge is dropped.
    assign sclk_rise = ~sclk_prev & sclk_cur & ~ss_fall & ~ss_rise;
    assign sclk_fall = sclk_prev & ~sclk_cur & ~ss_fall & ~ss_rise;
    assign frame_ok  = (bit_cnt == 5'd16);

    // Channel map: unpopulated channels read back as zero.
    always_comb begin
        chnl_val = 12'h000;
        case (chnl_ptr)
            3'd0:    chnl_val = ld_cell_lft;
            3'd4:    chnl_val = ld_cell_rght;
            3'd5:    chnl_val = steerPot;
            3'd6:    chnl_val = batt;
            default: chnl_val = 12'h000;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a frame spans one SS_n low window.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ss_fall) next_state = XFER;
            XFER:    if (ss_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Frame datapath: load at frame start, shift on SCLK edges, latch the command at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shft  <= 16'h0000;
            tx_shft  <= 16'h0000;
            bit_cnt  <= 5'd0;
            chnl_ptr <= 3'd0;
            MISO     <= IDLE_MISO;
        end else begin
            MISO <= (state == XFER) ? tx_shft[15] : IDLE_MISO;
            if (state == IDLE) begin
                if (ss_fall) begin
                    tx_shft <= {4'h0, chnl_val};
                    bit_cnt <= 5'd0;
                end
            end else begin
                if (ss_rise) begin
                    if (frame_ok) begin
                        chnl_ptr <= rx_shft[13:11];
                    end
                end else if (sclk_rise) begin
                    rx_shft <= {rx_shft[14:0], mosi_cur};
                    if (!frame_ok) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end else if (sclk_fall) begin
                    tx_shft <= {tx_shft[14:0], 1'b0};
                end
            end
        end
    end

`ifdef ADC_FRAME_CNT_EN
    // Count valid frames, wrapping naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 8'd0;
        end else if ((state == XFER) && ss_rise && frame_ok) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_adc128s_fc_model.sv
// tb_adc128s_fc_model: directed plus randomized frames against a channel-map
// reference model. The SPI master drops SCLK before SS_n falls so that every
// in-frame SCLK fall lies between two rises; MISO is sampled just before each rise.
module tb_adc128s_fc_model;

    localparam int HP = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] steerPot;
    logic [11:0] batt;
`ifdef ADC_FRAME_CNT_EN
    logic [7:0]  frame_cnt;
`endif

    int tests = 0;
    int fails = 0;
    int model_ptr = 0;
    int model_cnt = 0;

    logic [15:0] word;
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    adc128s_fc_model dut (
        .clk          (clk),
        .rst          (rst),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .steerPot     (steerPot),
        .batt         (batt)
`ifdef ADC_FRAME_CNT_EN
        ,
        .frame_cnt    (frame_cnt)
`endif
    );

    function automatic logic [11:0] modelVal(input int ch, input logic [11:0] lft,
                                             input logic [11:0] rght, input logic [11:0] pot,
                                             input logic [11:0] bat);
        logic [11:0] tbl [0:7];
        tbl = '{lft, 12'h000, 12'h000, 12'h000, rght, pot, bat, 12'h000};
        return tbl[ch];
    endfunction

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One frame of n SCLK rises; MOSI bit i is bits[31-i]. Returns the MISO
    // word seen on the first 16 rises and the model's prediction for it.
    task automatic applyStimulus(input logic [31:0] bits, input int n,
                                 input logic [11:0] lft, input logic [11:0] rght,
                                 input logic [11:0] pot, input logic [11:0] bat,
                                 input bit change_mid,
                                 output logic [15:0] obs, output logic [15:0] exp);
        logic [31:0] cmd;
        obs = 16'h0000;
        exp = {4'h0, modelVal(model_ptr, lft, rght, pot, bat)};
        ld_cell_lft  = lft;
        ld_cell_rght = rght;
        steerPot     = pot;
        batt         = bat;
        SCLK = 1'b0;
        MOSI = bits[31];
        waitClk(HP);
        SS_n = 1'b0;
        waitClk(HP);
        for (int i = 0; i < n; i++) begin
            if (i < 16) obs[15-i] = MISO;
            SCLK = 1'b1;
            if (change_mid && i == 4) begin
                ld_cell_lft  = 12'($urandom);
                ld_cell_rght = 12'($urandom);
                steerPot     = 12'($urandom);
                batt         = 12'($urandom);
            end
            waitClk(HP);
            if (i < n - 1) begin
                SCLK = 1'b0;
                MOSI = bits[30-i];
                waitClk(HP);
            end
        end
        waitClk(HP);
        SS_n = 1'b1;
        waitClk(2 * HP);
        if (n >= 16) begin
            cmd = bits >> (32 - n);
            model_ptr = int'(cmd[13:11]);
            model_cnt++;
        end
    endtask

    task automatic doReset();
        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        waitClk(3);
        rst = 1'b0;
        waitClk(4);
        model_ptr = 0;
        model_cnt = 0;
    endtask

    initial begin
        ld_cell_lft  = 12'h000;
        ld_cell_rght = 12'h000;
        steerPot     = 12'h000;
        batt         = 12'h000;

        doReset();
        checkOutput("reset_miso", {15'h0, MISO}, 16'h0000);
        waitClk(10);
        checkOutput("idle_miso", {15'h0, MISO}, 16'h0000);

        applyStimulus({16'h0000, 16'h0}, 16, 12'h5C3, 12'h111, 12'h222, 12'h333, 0, word, exp_word);
        checkOutput("first_frame_ch0", word, exp_word);
        applyStimulus({16'h0000, 16'h0}, 16, 12'h2A5, 12'h111, 12'h222, 12'h333, 0, word, exp_word);
        checkOutput("ch0_2A5", word, 16'h02A5);

        applyStimulus({16'h2800, 16'h0}, 16, 12'h2A5, 12'h111, 12'h7FF, 12'hD80, 0, word, exp_word);
        applyStimulus({16'h3000, 16'h0}, 16, 12'h2A5, 12'h111, 12'h7FF, 12'hD80, 0, word, exp_word);
        checkOutput("ch5_7FF", word, 16'h07FF);
        applyStimulus({16'h2000, 16'h0}, 16, 12'h2A5, 12'h123, 12'h7FF, 12'hD80, 0, word, exp_word);
        checkOutput("ch6_D80", word, 16'h0D80);
        applyStimulus({16'h1000, 16'h0}, 16, 12'h2A5, 12'h123, 12'h7FF, 12'hD80, 0, word, exp_word);
        checkOutput("ch4_123", word, 16'h0123);
        applyStimulus({16'h2800, 16'h0}, 16, 12'h2A5, 12'h123, 12'h7FF, 12'hD80, 0, word, exp_word);
        checkOutput("ch2_zero", word, 16'h0000);
        checkOutput("idle_after_frame", {15'h0, MISO}, 16'h0000);

        applyStimulus({16'h3000, 16'h0}, 9, 12'h2A5, 12'h123, 12'h456, 12'h789, 0, word, exp_word);
        applyStimulus({16'h0000, 16'h0}, 16, 12'h2A5, 12'h123, 12'h456, 12'h789, 0, word, exp_word);
        checkOutput("abort_keeps_ch5", word, 16'h0456);

        applyStimulus({16'h2800, 16'h0}, 16, 12'h2A5, 12'h123, 12'h456, 12'h789, 1, word, exp_word);
        checkOutput("midframe_change_ch0", word, exp_word);

        SCLK = 1'b0;
        waitClk(HP);
        SS_n = 1'b0;
        waitClk(HP);
        for (int i = 0; i < 5; i++) begin
            SCLK = 1'b1;
            waitClk(HP);
            SCLK = 1'b0;
            waitClk(HP);
        end
        rst = 1'b1;
        waitClk(2);
        rst = 1'b0;
        waitClk(HP);
        SCLK = 1'b1;
        SS_n = 1'b1;
        waitClk(2 * HP);
        model_ptr = 0;
        model_cnt = 0;
        applyStimulus({16'h0000, 16'h0}, 16, 12'hABC, 12'h123, 12'h456, 12'h789, 0, word, exp_word);
        checkOutput("after_rst_ch0", word, 16'h0ABC);

        applyStimulus(32'h03000000, 20, 12'hABC, 12'h123, 12'h456, 12'h789, 0, word, exp_word);
        applyStimulus({16'h0000, 16'h0}, 16, 12'hABC, 12'h123, 12'h456, 12'hE1F, 0, word, exp_word);
        checkOutput("over16_ch6", word, 16'h0E1F);

        for (int k = 0; k < 30; k++) begin
            logic [31:0] bits;
            int n;
            bits = $urandom;
            case ($urandom_range(0, 5))
                0:       n = 10;
                1:       n = 19;
                default: n = 16;
            endcase
            applyStimulus(bits, n, 12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                          bit'($urandom_range(0, 1)), word, exp_word);
            if (n >= 16) checkOutput("random_frame", word, exp_word);
            checkOutput("random_idle", {15'h0, MISO}, 16'h0000);
        end

`ifdef ADC_FRAME_CNT_EN
        checkOutput("frame_cnt_random", {8'h0, frame_cnt}, 16'(model_cnt % 256));
        doReset();
        checkOutput("frame_cnt_reset", {8'h0, frame_cnt}, 16'h0000);
        for (int k = 0; k < 300; k++) begin
            applyStimulus({16'h0000, 16'h0}, 16, 12'h001, 12'h002, 12'h003, 12'h004, 0, word, exp_word);
        end
        checkOutput("frame_cnt_300", {8'h0, frame_cnt}, 16'd44);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
